// File: rtl/module_display_mux.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// Holds a 16-bit hex value and presents one nibble per scan slot, with
// active-low digit anodes. New values are staged and committed only at the
// frame boundary, so a frame never shows a mix of old and new digits. Each
// slot opens with a short all-off window against ghosting, and leading zeros
// can optionally be blanked.
module module_display_mux #(
  parameter int CLK_DIV      = 27000,
  parameter int GHOST_CYCLES = 270
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        load_valid,
  input  logic        lz_en,
  output logic        pending,
  output logic [3:0]  nibble,
  output logic [3:0]  anodes,
  output logic [1:0]  digit_idx
);

  localparam int             CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GHOST_LIM = CNT_W'(GHOST_CYCLES);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  logic [15:0]      shown_q, shown_d;
  logic [15:0]      staged_q, staged_d;
  logic             pending_q, pending_d;

  logic slot_end;
  logic frame_end;
  logic commit;
  logic lz_zero;
  logic suppress;
  logic ghost;

  // Next-state: slot/digit counters, staged-value capture and frame-boundary commit
  always_comb begin
    slot_end    = (div_cnt_q == CNT_LAST);
    frame_end   = slot_end && (digit_idx_q == 2'd3);
    commit      = frame_end && pending_q;
    div_cnt_d   = slot_end ? '0 : div_cnt_q + 1'b1;
    digit_idx_d = slot_end ? digit_idx_q + 2'd1 : digit_idx_q;
    // The old staged value commits even if a new load lands on the same edge
    shown_d     = commit ? staged_q : shown_q;
    staged_d    = load_valid ? data_in : staged_q;
    // A load on the boundary keeps pending set so the new value waits a frame
    pending_d   = load_valid | (pending_q & ~commit);
  end

  // State registers, all cleared asynchronously (a staged value is discarded)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      digit_idx_q <= 2'd0;
      shown_q     <= 16'h0000;
      staged_q    <= 16'h0000;
      pending_q   <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      shown_q     <= shown_d;
      staged_q    <= staged_d;
      pending_q   <= pending_d;
    end
  end

  // Output decode: nibble select, leading-zero blanking and ghost window
  always_comb begin
    lz_zero = 1'b0;
    unique case (digit_idx_q)
      2'd1:    lz_zero = (shown_q[15:4]  == 12'h000);
      2'd2:    lz_zero = (shown_q[15:8]  == 8'h00);
      2'd3:    lz_zero = (shown_q[15:12] == 4'h0);
      default: lz_zero = 1'b0;  // rightmost digit always shown
    endcase
    suppress = lz_en & lz_zero;
    ghost    = (div_cnt_q < GHOST_LIM);
    nibble   = shown_q[{digit_idx_q, 2'b00} +: 4];
    anodes   = (ghost | suppress) ? 4'b1111 : ~(4'b0001 << digit_idx_q);
  end

  assign pending   = pending_q;
  assign digit_idx = digit_idx_q;

endmodule
